// File: rtl/mac8_exec_sequencer.sv
// Execution-phase sequencer for the MAC8 array: drives FIFO read strobes and
// the MAC En_in/Clr_in controls so each accumulator sees exactly DEPTH products.
module mac8_exec_sequencer #(
    parameter int DEPTH   = 8,
    parameter int MAC_LAT = 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    a_empty,
    input  logic          b_empty,
    output logic [7:0]    a_rden,
    output logic          b_rden,
    output logic          En_in,
    output logic          Clr_in,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state,
    output logic [CW-1:0] dbg_rd_cnt
);
    // Drain counter is at least one bit wide even when MAC_LAT is zero.
    localparam int LW = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] rd_cnt, rd_cnt_nx;
    logic [LW-1:0] lat_cnt, lat_cnt_nx;
    logic          rd_ok;
    logic          rd;

    assign rd_ok = (a_empty == 8'h00) && !b_empty && (rd_cnt < CW'(DEPTH));

    always_comb begin
        state_nx   = state;
        rd_cnt_nx  = rd_cnt;
        lat_cnt_nx = lat_cnt;
        rd         = 1'b0;
        Clr_in     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                rd_cnt_nx  = '0;
                lat_cnt_nx = '0;
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                Clr_in   = 1'b1;
                busy     = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                rd   = rd_ok;
                if (rd_ok) begin
                    rd_cnt_nx = rd_cnt + CW'(1);
                    if (rd_cnt == CW'(DEPTH - 1)) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // One cycle for the final En_in, then MAC_LAT more for the result.
                busy = 1'b1;
                if (lat_cnt == LW'(MAC_LAT)) state_nx = DONE;
                else                         lat_cnt_nx = lat_cnt + LW'(1);
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            lat_cnt <= '0;
            En_in   <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_cnt  <= rd_cnt_nx;
            lat_cnt <= lat_cnt_nx;
            // FIFO data lands on the read edge, so the MAC samples it one cycle later.
            En_in   <= rd;
        end
    end

    assign a_rden     = {8{rd}};
    assign b_rden     = rd;
    assign dbg_state  = state;
    assign dbg_rd_cnt = rd_cnt;

endmodule

// File: tb/tb_mac8_exec_sequencer.sv
// Scoreboard bench for mac8_exec_sequencer with behavioural FIFOs and MAC8 model.
module tb_mac8_exec_sequencer;
    localparam int DEPTH   = 8;
    localparam int MAC_LAT = 1;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    a_empty = 8'hFF;
    logic          b_empty = 1'b1;
    logic [7:0]    a_rden;
    logic          b_rden;
    logic          En_in;
    logic          Clr_in;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;
    logic [CW-1:0] dbg_rd_cnt;

    mac8_exec_sequencer #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_empty(a_empty), .b_empty(b_empty),
        .a_rden(a_rden), .b_rden(b_rden),
        .En_in(En_in), .Clr_in(Clr_in),
        .busy(busy), .done(done),
        .dbg_state(dbg_state), .dbg_rd_cnt(dbg_rd_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural FIFOs and MAC: data updates on the read edge, MAC samples on En_in edge.
    int         aq[8][$];
    int         bq[$];
    int         a_dat[8];
    int         b_dat = 0;
    int         acc[8];
    logic [7:0] s_rd = '0;
    logic       s_b = 1'b0, s_en = 1'b0, s_clr = 1'b0;

    always @(negedge clk) begin
        s_rd  = a_rden;
        s_b   = b_rden;
        s_en  = En_in;
        s_clr = Clr_in;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            for (int r = 0; r < 8; r++) begin
                aq[r].delete();
                acc[r]   = 0;
                a_dat[r] = 0;
            end
            bq.delete();
            b_dat = 0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                if (s_clr)     acc[r] = 0;
                else if (s_en) acc[r] = acc[r] + a_dat[r] * b_dat;
            end
            for (int r = 0; r < 8; r++)
                if (s_rd[r] && aq[r].size() > 0) a_dat[r] = aq[r].pop_front();
            if (s_b && bq.size() > 0) b_dat = bq.pop_front();
        end
        #2;
        for (int r = 0; r < 8; r++) a_empty[r] = (aq[r].size() == 0);
        b_empty = (bq.size() == 0);
    end

    // Scoreboard: expected edge count at which done first appears.
    int   exp_q[$];
    logic prev_rd = 1'b0, done_q = 1'b0;
    int   rd_pulses = 0, en_pulses = 0, clr_pulses = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0; done_q = 1'b0;
            rd_pulses = 0; en_pulses = 0; clr_pulses = 0;
        end else begin
            check("en_follows_rd", int'(En_in), int'(prev_rd));
            check("clr_en_excl", int'(Clr_in & En_in), 0);
            check("rden_equal", int'(a_rden == {8{b_rden}}), 1);
            check("busy_done_excl", int'(busy & done), 0);
            if (a_rden[0]) check("read_not_empty", int'((a_empty == 8'h00) && !b_empty), 1);
            if (Clr_in) begin
                rd_pulses = 0; en_pulses = 0;
                clr_pulses++;
            end
            rd_pulses += int'(a_rden[0]);
            en_pulses += int'(En_in);
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_cycle", cyc, exp_q.pop_front());
                    check("rd_cnt_done", int'(dbg_rd_cnt), DEPTH);
                    check("read_pulses", rd_pulses, DEPTH);
                    check("en_pulses", en_pulses, DEPTH);
                    check("clr_pulses", clr_pulses, 1);
                    // Row r: sum_k (r+1+k)(k+1) = 36r + 204
                    for (int r = 0; r < 8; r++) check($sformatf("c_out[%0d]", r), acc[r], 36 * r + 204);
                end
                clr_pulses = 0;
            end
            prev_rd = a_rden[0];
            done_q  = done;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_a(input int n);
        for (int k = 0; k < n; k++)
            for (int r = 0; r < 8; r++) aq[r].push_back(r + 1 + k);
    endtask

    task automatic fill_b(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) bq.push_back(v);
    endtask

    // start raised now is sampled on the next edge (T0 = cyc+1); done appears
    // just after edge T0+DEPTH+2+MAC_LAT, i.e. during cycle T0+DEPTH+3+MAC_LAT.
    task automatic launch(input int stall);
        exp_q.push_back(cyc + 1 + DEPTH + 2 + MAC_LAT + stall);
        start = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("done_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int t0;
        int n;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_state", int'(dbg_state), 0);
        check("rst_rd_cnt", int'(dbg_rd_cnt), 0);
        check("rst_a_rden", int'(a_rden), 0);
        check("rst_b_rden", int'(b_rden), 0);
        check("rst_en", int'(En_in), 0);
        check("rst_clr", int'(Clr_in), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step();

        // Nominal run, then hold start high past done.
        fill_a(8); fill_b(1, 8);
        step();
        launch(0);
        wait_done();
        repeat (30) begin
            check("hold_done", int'(done), 1);
            check("hold_state", int'(dbg_state), 4);
            step();
        end
        check("hold_no_clr", clr_pulses, 0);
        start = 1'b0;
        step();
        check("idle_after_drop", int'(dbg_state), 0);
        step();

        // Stall: B runs dry after 4 reads, refilled 5 cycles late.
        fill_a(8); fill_b(1, 4);
        step();
        t0 = cyc + 1;
        launch(5);
        n = 0;
        while (cyc < t0 + 10 && n < 50) begin
            if (cyc == t0 + 7) begin
                check("stall_rd_cnt", int'(dbg_rd_cnt), 4);
                check("stall_no_read", int'(b_rden), 0);
                check("stall_en_low", int'(En_in), 0);
            end
            step();
            n++;
        end
        fill_b(5, 8);
        wait_done();
        start = 1'b0;
        step(); step();

        // Overfull: 9 entries available, only DEPTH may be consumed.
        fill_a(9); fill_b(1, 9);
        step();
        launch(0);
        wait_done();
        check("overfull_rd_cnt", int'(dbg_rd_cnt), DEPTH);
        check("overfull_a_left", aq[0].size(), 1);
        check("overfull_b_left", bq.size(), 1);
        start = 1'b0;
        step(); step();

        // Reset in the middle of RUN.
        for (int r = 0; r < 8; r++) aq[r].delete();
        bq.delete();
        fill_a(8); fill_b(1, 8);
        step();
        launch(0);
        n = 0;
        while (dbg_rd_cnt != CW'(3) && n < 50) begin
            step();
            n++;
        end
        check("reach_rd3", int'(dbg_rd_cnt), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", int'(dbg_state), 0);
        check("mid_rst_a_rden", int'(a_rden), 0);
        check("mid_rst_b_rden", int'(b_rden), 0);
        check("mid_rst_en", int'(En_in), 0);
        check("mid_rst_clr", int'(Clr_in), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        exp_q.delete();
        start = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        fill_a(8); fill_b(1, 8);
        step();
        launch(0);
        wait_done();
        start = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
